// File: rtl/fifo_share_ctrl_pkg.sv
// Shared defaults for the FIFO sharing controller: producer count, data width,
// FIFO depth and the occupancy counter width.
package fifo_share_ctrl_pkg;

  localparam int N_DEF     = 4;
  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 8;

  // Occupancy must represent 0..DEPTH inclusive.
  localparam int CNT_W = $clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set bit of cand searching upward
// from ptr, wrapping modulo N.
module fifo_rr_pick
  import fifo_share_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int PTR_W = $clog2(N_DEF)
) (
  input  logic [N-1:0]     cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N)) sum = sum - (PTR_W + 1)'(N);
      idx = sum[PTR_W-1:0];
      if (!valid && cand[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Round-robin write arbiter and read sequencer in front of one shared FIFO;
// tracks occupancy so only legal wen/ren commands reach the FIFO.
module fifo_share_ctrl
  import fifo_share_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   wdata,
  output logic [N-1:0]     gnt,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic             fifo_wen,
  output logic             fifo_ren,
  output logic [W-1:0]     fifo_din,
  input  logic [W-1:0]     fifo_dout,
  input  logic             fifo_error,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             err_sticky
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [N-1:0]     cand;
  logic [N-1:0]     pick;
  logic             pick_valid;
  logic             do_wr;
  logic             do_rd;
  logic [W-1:0]     sel_data;
  logic [CNT_W-1:0] occ_next;

  // The producer granted last cycle sits out this edge.
  assign cand = req & ~gnt;

  fifo_rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .cand  (cand),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Both decisions use the current occupancy, so a slot freed by a read
  // only becomes writable on the following edge.
  assign do_wr = pick_valid && (occupancy < CNT_W'(DEPTH));
  assign do_rd = rd_req && (occupancy != '0);

  always_comb begin
    sel_data = '0;
    ptr_next = ptr;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        sel_data = wdata[i*W +: W];
        ptr_next = PTR_W'((i + 1) % N);
      end
    end
  end

  always_comb begin
    occ_next = occupancy;
    case ({do_wr, do_rd})
      2'b10:   occ_next = occupancy + CNT_W'(1);
      2'b01:   occ_next = occupancy - CNT_W'(1);
      default: occ_next = occupancy;
    endcase
  end

  assign rd_data = fifo_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      ptr        <= '0;
      fifo_wen   <= 1'b0;
      fifo_ren   <= 1'b0;
      fifo_din   <= '0;
      rd_valid   <= 1'b0;
      occupancy  <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      err_sticky <= 1'b0;
    end else begin
      gnt        <= do_wr ? pick : '0;
      fifo_wen   <= do_wr;
      if (do_wr) begin
        fifo_din <= sel_data;
        ptr      <= ptr_next;
      end
      fifo_ren   <= do_rd;
      rd_valid   <= fifo_ren;
      occupancy  <= occ_next;
      full       <= (occ_next == CNT_W'(DEPTH));
      empty      <= (occ_next == '0);
      err_sticky <= err_sticky | fifo_error;
    end
  end

endmodule
